// File: rtl/dvp_rgb565_packer_if.sv
// Camera-side and DDR-write-side signals of the DVP RGB565 packer.
// master: the packer (samples camera pins, drives write port and status).
// slave : the surrounding system (drives camera pins, consumes write port).
interface dvp_rgb565_packer_if;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        wr_load;
    logic        wfifo_wren;
    logic [31:0] wfifo_din;
    logic        frame_done;
    logic        frame_err;
    logic [11:0] line_count;
    logic [7:0]  frame_count;

    modport master (
        input  cam_vsync, cam_href, cam_data,
        output wr_load, wfifo_wren, wfifo_din,
        output frame_done, frame_err, line_count, frame_count
    );

    modport slave (
        output cam_vsync, cam_href, cam_data,
        input  wr_load, wfifo_wren, wfifo_din,
        input  frame_done, frame_err, line_count, frame_count
    );
endinterface

// File: rtl/dvp_rgb565_packer.sv
// DVP RGB565 byte stream -> 32-bit RGB888 words for the DDR write FIFO.
// Crops each frame to IMAGE_WIDTH x IMAGE_HEIGHT, issues the per-frame
// write-address reload pulse and reports line/frame status.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_SYNC | after reset; all data ignored until the first frame start
// LOAD      | wr_load high for LOAD_PULSE_LEN cycles; frame state cleared
// ACTIVE    | capturing lines; next frame start closes the frame
module dvp_rgb565_packer #(
    parameter int IMAGE_WIDTH     = 800,
    parameter int IMAGE_HEIGHT    = 480,
    parameter int VSYNC_POL       = 1,
    parameter int HIGH_BYTE_FIRST = 1,
    parameter int LOAD_PULSE_LEN  = 4
) (
    input  logic                       i_pixel_clock,
    input  logic                       i_reset,
    dvp_rgb565_packer_if.master        bus
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LOAD      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    localparam logic [11:0] W12       = IMAGE_WIDTH[11:0];
    localparam logic [11:0] H12       = IMAGE_HEIGHT[11:0];
    localparam logic [3:0]  LOAD_INIT = 4'(LOAD_PULSE_LEN - 1);
    localparam logic        VS_ACT    = VSYNC_POL[0];

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_vs_s1;
    logic        r_href_s1;
    logic [7:0]  r_data_s1;
    logic        r_vs_act_d;
    logic        r_href_d;

    logic [3:0]  r_load_cnt;
    logic        r_phase;
    logic [7:0]  r_byte0;
    logic [11:0] r_x;
    logic [11:0] r_line_cnt;
    logic        r_err;

    logic        r_pix_ok;
    logic [15:0] r_pix;

    logic        r_wren;
    logic [31:0] r_din;
    logic        r_frame_done;
    logic        r_frame_err;
    logic [7:0]  r_frame_count;

    logic        w_vs_act;
    logic        w_vs_start;
    logic        w_capture;
    logic        w_pix_form;
    logic        w_pix_keep;
    logic [15:0] w_pix16;

    // Frame start detect and capture qualifiers, all from registered inputs
    always_comb begin
        w_vs_act   = (r_vs_s1 == VS_ACT);
        w_vs_start = w_vs_act && !r_vs_act_d;
        // frame end wins over any byte arriving in the same cycle
        w_capture  = (r_state == ACTIVE) && !w_vs_start && r_href_s1;
        w_pix_form = w_capture && r_phase;
        w_pix16    = (HIGH_BYTE_FIRST != 0) ? {r_byte0, r_data_s1} : {r_data_s1, r_byte0};
        w_pix_keep = w_pix_form && (r_x < W12) && (r_line_cnt < H12);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_SYNC: if (w_vs_start) w_state_nxt = LOAD;
            LOAD:      if (r_load_cnt == 4'd0) w_state_nxt = ACTIVE;
            ACTIVE:    if (w_vs_start) w_state_nxt = LOAD;
            default:   w_state_nxt = WAIT_SYNC;
        endcase
    end

    // State register
    always_ff @(posedge i_pixel_clock) begin
        if (i_reset) r_state <= WAIT_SYNC;
        else         r_state <= w_state_nxt;
    end

    // Input sampling, capture datapath, counters and status outputs
    always_ff @(posedge i_pixel_clock) begin
        if (i_reset) begin
            r_vs_s1       <= 1'b0;
            r_href_s1     <= 1'b0;
            r_data_s1     <= 8'd0;
            // treated as already active so a frame in progress at reset
            // release cannot produce a start edge
            r_vs_act_d    <= 1'b1;
            r_href_d      <= 1'b0;
            r_load_cnt    <= 4'd0;
            r_phase       <= 1'b0;
            r_byte0       <= 8'd0;
            r_x           <= 12'd0;
            r_line_cnt    <= 12'd0;
            r_err         <= 1'b0;
            r_pix_ok      <= 1'b0;
            r_pix         <= 16'd0;
            r_wren        <= 1'b0;
            r_din         <= 32'd0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_vs_s1      <= bus.cam_vsync;
            r_href_s1    <= bus.cam_href;
            r_data_s1    <= bus.cam_data;
            r_vs_act_d   <= w_vs_act;
            r_href_d     <= r_href_s1;
            r_frame_done <= 1'b0;

            r_pix_ok <= w_pix_keep;
            if (w_pix_keep) r_pix <= w_pix16;
            r_wren <= r_pix_ok;
            if (r_pix_ok) begin
                r_din <= {8'h00,
                          r_pix[15:11], r_pix[15:13],
                          r_pix[10:5],  r_pix[10:9],
                          r_pix[4:0],   r_pix[4:2]};
            end

            if (w_state_nxt == LOAD && r_state != LOAD) begin
                r_load_cnt <= LOAD_INIT;
            end else if (r_state == LOAD && r_load_cnt != 4'd0) begin
                r_load_cnt <= r_load_cnt - 4'd1;
            end

            if (r_state == LOAD) begin
                r_line_cnt <= 12'd0;
                r_x        <= 12'd0;
                r_phase    <= 1'b0;
                r_err      <= 1'b0;
            end else if (r_state == ACTIVE) begin
                if (w_vs_start) begin
                    r_frame_done  <= 1'b1;
                    r_frame_err   <= r_err || (r_line_cnt != H12);
                    r_frame_count <= r_frame_count + 8'd1;
                end else if (r_href_s1) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_byte0 <= r_data_s1;
                    end else if (r_x != 12'hFFF) begin
                        r_x <= r_x + 12'd1;
                    end
                end else if (r_href_d) begin
                    if (r_x != 12'd0 && r_line_cnt != 12'hFFF) r_line_cnt <= r_line_cnt + 12'd1;
                    if (r_x != W12 || r_phase) r_err <= 1'b1;
                    r_x     <= 12'd0;
                    r_phase <= 1'b0;
                end
            end
        end
    end

    assign bus.wr_load     = (r_state == LOAD);
    assign bus.wfifo_wren  = r_wren;
    assign bus.wfifo_din   = r_din;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_err   = r_frame_err;
    assign bus.line_count  = r_line_cnt;
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_dvp_rgb565_packer.sv
// Randomized frame stimulus checked against a line/frame level model.
module tb_dvp_rgb565_packer;
    localparam int W    = 16;
    localparam int H    = 6;
    localparam int LPL  = 4;
    localparam int VPOL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dvp_rgb565_packer_if bus ();

    dvp_rgb565_packer #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .VSYNC_POL(VPOL),
        .HIGH_BYTE_FIRST(1), .LOAD_PULSE_LEN(LPL)
    ) dut (
        .i_pixel_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    typedef struct { logic [31:0] din; int k; } pix_t;
    typedef struct { logic err; logic [7:0] fc; } frm_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    pix_t exp_q[$];
    frm_t frm_q[$];
    logic [31:0] dins[$];
    logic [7:0]  lb[$];
    int n_wren = 0, n_done = 0, load_len = 0, load_pulses = 0, exp_loads = 0;
    logic [31:0] last_exp = 32'd0;

    bit m_active = 0;
    bit m_err = 0;
    int m_counted = 0;
    int m_fc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp565(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r8 = (r5 << 3) | (r5 >> 2);
        g8 = (g6 << 2) | (g6 >> 4);
        b8 = (b5 << 3) | (b5 >> 2);
        return {8'h00, 8'(r8), 8'(g8), 8'(b8)};
    endfunction

    // compare process: every cycle against the model queues
    always @(negedge clk) begin : mon
        pix_t p;
        frm_t f;
        if (rst) begin
            last_exp = 32'd0;
            load_len = 0;
        end else begin
            if (bus.wfifo_wren) begin
                n_wren++;
                dins.push_back(bus.wfifo_din);
                if (exp_q.size() == 0) chk("spurious_wren", 1, 0);
                else begin
                    p = exp_q.pop_front();
                    chk("wfifo_din", bus.wfifo_din, p.din);
                    chk("wren_latency", cyc - p.k, 2);
                    last_exp = p.din;
                end
            end else begin
                chk("din_hold", bus.wfifo_din, last_exp);
            end
            if (bus.wr_load) load_len++;
            else if (load_len > 0) begin
                chk("wr_load_len", load_len, LPL);
                load_pulses++;
                load_len = 0;
            end
            if (bus.frame_done) begin
                n_done++;
                if (frm_q.size() == 0) chk("spurious_frame_done", 1, 0);
                else begin
                    f = frm_q.pop_front();
                    chk("frame_err", bus.frame_err, f.err);
                    chk("frame_count", bus.frame_count, f.fc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.cam_href = 1'b0;
            bus.cam_data = 8'($urandom);
        end
    endtask

    task automatic vsync(input bit keep_href);
        if (m_active) chk("line_count", bus.line_count, m_counted);
        @(negedge clk);
        bus.cam_vsync = 1'(VPOL);
        bus.cam_href  = keep_href;
        bus.cam_data  = 8'($urandom);
        if (m_active) begin
            frm_q.push_back('{err: (m_err || (m_counted != H)), fc: 8'(m_fc + 1)});
            m_fc++;
        end
        m_active = 1; m_counted = 0; m_err = 0; exp_loads++;
        if (keep_href) begin
            @(negedge clk);
            bus.cam_data = 8'($urandom);
        end
        repeat (2) begin
            @(negedge clk);
            bus.cam_href = 1'b0;
        end
        bus.cam_vsync = ~1'(VPOL);
        idle(8);
    endtask

    // drives the bytes in lb as one line; optional reset release / frame cut
    task automatic drive_line(input int rel_at, input bit cut);
        int pix = 0;
        int n = lb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == rel_at) rst = 1'b0;
            bus.cam_href = 1'b1;
            bus.cam_data = lb[i];
            if (i % 2 == 1) begin
                if (m_active && m_counted < H && pix < W)
                    exp_q.push_back('{din: exp565({lb[i-1], lb[i]}), k: cyc + 1});
                pix++;
            end
        end
        if (cut) vsync(1'b1);
        else begin
            idle(4);
            if (m_active) begin
                if (pix > 0) m_counted++;
                if (pix != W || (n % 2) == 1) m_err = 1;
            end
        end
    endtask

    task automatic rand_line(input int n);
        lb.delete();
        for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
        drive_line(-1, 1'b0);
    endtask

    task automatic red_line();
        lb.delete();
        for (int i = 0; i < W; i++) begin
            lb.push_back(8'hF8);
            lb.push_back(8'h00);
        end
        drive_line(-1, 1'b0);
    endtask

    initial begin : stim
        int mark;
        int nl;
        int r;
        bus.cam_vsync = ~1'(VPOL);
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_wr_load", bus.wr_load, 0);
        chk("rst_wren", bus.wfifo_wren, 0);
        chk("rst_din", bus.wfifo_din, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_line_count", bus.line_count, 0);
        chk("rst_frame_count", bus.frame_count, 0);
        rst = 1'b0;
        idle(4);

        // two full red frames
        vsync(1'b0);
        repeat (H) red_line();
        vsync(1'b0);
        idle(3);
        chk("f1_frame_count", bus.frame_count, 1);
        chk("f1_frame_err", bus.frame_err, 0);
        chk("f1_done_pulses", n_done, 1);
        chk("f1_wren_total", n_wren, W * H);
        chk("f1_red_word", dins[0], 32'h00FF0000);
        repeat (H) red_line();
        vsync(1'b0);

        // pure green then pure blue at the start of a line
        mark = n_wren;
        lb.delete();
        lb.push_back(8'h07); lb.push_back(8'hE0);
        lb.push_back(8'h00); lb.push_back(8'h1F);
        for (int i = 4; i < 2 * W; i++) lb.push_back(8'($urandom));
        drive_line(-1, 1'b0);
        chk("green_word", dins[mark], 32'h0000FF00);
        chk("blue_word", dins[mark + 1], 32'h000000FF);
        repeat (H - 1) rand_line(2 * W);

        // short odd line among full lines
        vsync(1'b0);
        rand_line(2 * W);
        mark = n_wren;
        rand_line(2 * (W / 2) + 1);
        chk("odd_line_wrens", n_wren - mark, W / 2);
        repeat (H - 2) rand_line(2 * W);
        vsync(1'b0);
        idle(3);
        chk("odd_line_frame_err", bus.frame_err, 1);

        // oversize frame: extra lines and extra pixels
        mark = n_wren;
        repeat (H + 3) rand_line(2 * W + 12);
        chk("oversize_line_count", bus.line_count, H + 3);
        chk("oversize_wrens", n_wren - mark, W * H);
        vsync(1'b0);
        idle(3);
        chk("oversize_frame_err", bus.frame_err, 1);

        // randomized frames
        for (int f = 0; f < 5; f++) begin
            nl = H - 1 + int'($urandom_range(0, 2));
            for (int l = 0; l < nl; l++) begin
                r = int'($urandom_range(0, 11));
                if (r < 7)       rand_line(2 * W);
                else if (r == 7) rand_line(2 * W + 1);
                else if (r == 8) rand_line(2 * int'($urandom_range(1, W - 1)) + 1);
                else if (r == 9) rand_line(2 * W + 2 * int'($urandom_range(1, 4)));
                else if (r == 10) rand_line(1);
                else             rand_line(2 * int'($urandom_range(1, W - 1)));
            end
            vsync(1'b0);
        end

        // reset in mid-frame, released in the middle of a line
        rand_line(2 * W);
        rand_line(2 * W);
        @(negedge clk);
        rst = 1'b1;
        m_active = 0;
        m_fc = 0;
        idle(2);
        rand_line(2 * W);
        lb.delete();
        for (int i = 0; i < 2 * W; i++) lb.push_back(8'($urandom));
        drive_line(7, 1'b0);
        rand_line(2 * W);
        rand_line(2 * W);
        vsync(1'b0);
        repeat (H) rand_line(2 * W);
        vsync(1'b0);
        idle(3);
        chk("post_reset_frame_count", bus.frame_count, 1);
        chk("post_reset_frame_err", bus.frame_err, 0);

        // frame start while href is high in the middle of a line
        rand_line(2 * W);
        rand_line(2 * W);
        lb.delete();
        for (int i = 0; i < 9; i++) lb.push_back(8'($urandom));
        drive_line(-1, 1'b1);
        idle(1);
        chk("cut_frame_err", bus.frame_err, 1);
        chk("cut_frame_count", bus.frame_count, 2);
        repeat (H) red_line();
        vsync(1'b0);
        idle(3);
        chk("after_cut_frame_err", bus.frame_err, 0);

        idle(20);
        chk("pixels_outstanding", exp_q.size(), 0);
        chk("frames_outstanding", frm_q.size(), 0);
        chk("wr_load_pulses", load_pulses, exp_loads);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dvp_rgb565_packer.md
Name: dvp_rgb565_packer

Overview:
- Sits between the camera DVP pins and the DDR3 write port (wr_load / wfifo_wren / wfifo_din).
- Samples the 8-bit OV5640 RGB565 byte stream and assembles byte pairs into RGB888 words, one 32-bit word per pixel.
- Issues the per-frame write-source reload pulse and crops every frame to IMAGE_WIDTH x IMAGE_HEIGHT.
- Reports line/frame status. Runs entirely in the camera pixel clock domain.

Parameters:
- IMAGE_WIDTH, 800: pixels written per line; excess pixels dropped.
- IMAGE_HEIGHT, 480: lines written per frame; excess lines dropped.
- VSYNC_POL, 1: active level of cam_vsync.
- HIGH_BYTE_FIRST, 1: 1 = first byte of pair is RGB565[15:8].
- LOAD_PULSE_LEN, 4: wr_load high time in clocks, range 1..15.

Ports:
- pixel_clock  in  1  camera PCLK; sole clock.
- reset  in  1  synchronous, active-high.
- cam_vsync  in  1  frame sync, polarity per VSYNC_POL.
- cam_href  in  1  line valid, active-high.
- cam_data  in  8  pixel byte.
- wr_load  out  1  write-address reload pulse to DDR controller.
- wfifo_wren  out  1  write-FIFO write enable.
- wfifo_din  out  32  {8'h00, R8, G8, B8}.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- frame_err  out  1  sticky error flag for last completed frame.
- line_count  out  12  lines accepted in current frame.
- frame_count  out  8  completed frames, wraps.

Behaviour:
- Reset (synchronous, active-high): every output 0; state WAIT_SYNC; input registers, byte phase and counters cleared.
- Input stage: cam_vsync/cam_href/cam_data registered once (s1). All decisions use s1 values.
- vs_start is defined as the s1 vsync transition inactive->active.
- States:
  - WAIT_SYNC: ignore all data. On vs_start go to LOAD. After reset the partial frame in progress is never written.
  - LOAD: wr_load=1 for exactly LOAD_PULSE_LEN cycles. Clear line_count, x counter, byte phase, in-frame error. Then go to ACTIVE. Data arriving during LOAD is discarded.
  - ACTIVE: capture, described below. On vs_start:
    - frame_done=1 for one cycle.
    - frame_err <= in-frame error OR (line_count != IMAGE_HEIGHT).
    - frame_count += 1 (8-bit wrap).
    - Go to LOAD.
- Capture in ACTIVE, when s1 href=1:
  - Byte phase toggles each cycle.
  - Phase 0 byte is held.
  - On the phase 1 byte, form pix16 per HIGH_BYTE_FIRST.
  - If x < IMAGE_WIDTH and line_count < IMAGE_HEIGHT: wfifo_wren=1 next cycle; wfifo_din = {8'h00, R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]}.
  - x increments on every formed pixel, saturating at 4095.
- Latency: second byte on cam_data at edge k -> wfifo_wren/wfifo_din registered at edge k+2. wfifo_wren is a single-cycle pulse per pixel. wfifo_din holds its value between pulses.
- Line end (s1 href 1->0):
  - If x>0, line_count += 1 (saturating at 4095).
  - If x != IMAGE_WIDTH, or phase was 1 (odd byte count), set in-frame error.
  - The orphan byte is discarded.
  - x and phase are cleared.
- Lines beyond IMAGE_HEIGHT: counted and flagged; never written.
- Pixels beyond IMAGE_WIDTH: flagged; never written.
- vs_start while href=1: frame-end handling takes priority. The partial pixel is discarded and its line is not counted.
- reset asserted mid-frame: immediate return to WAIT_SYNC, no further wren or wr_load, frame_done not pulsed.
- No backpressure: the DDR write FIFO is sized for a full line burst. wfifo_wren is never stalled.

Test Plan:
- Reset, then 2 full frames of 800x480 with bytes 0xF8,0x00 (pure red) -> frame 1:
  - wr_load high 4 cycles after first vs_start.
  - 384000 wren pulses, each wfifo_din=32'h00FF0000.
  - frame_done once, frame_err=0, frame_count=1.
- Pixel 0x07E0 then 0x001F, HIGH_BYTE_FIRST=1 -> 32'h0000FF00 then 32'h000000FF. wren appears 2 clocks after the second byte of each pixel.
- Release reset mid-frame (line 200 active) -> zero wren until the next vs_start. The following frame is complete and error-free.
- Line of 803 bytes (401 pixels + orphan) among lines of 1600 bytes -> 401 wrens on that line, orphan dropped, frame_err=1 at frame end.
- 500 lines of 1700 bytes each ->
  - Only 480 lines x 800 wrens are written.
  - line_count reads 500 before frame end; frame_err=1.
- vs_start asserted while href high mid-line -> frame_done pulse, wr_load pulse, no spurious wren, and the first pixel of the new frame is correct.
